result_flags_register: RTL and testbench

Consumer end of the `resultFlagsControl` bus. Holds the architectural condition flags O, N, Z and C, updating them from ALU, shifter or multiplier results as the registered controller command directs. Multiplier flag updates complete out-of-line, signalled by a pending/stall indication. Provides a 4-deep shadow stack for saving and restoring flags across interrupt entry and return. Sits in the execute datapath beside the ALU, shifter and multiplier.

---
 rtl/result_flags_register.sv | 250 +++++++++++++++++++++++++
 tb/tb_result_flags_register.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/result_flags_register.sv
// result_flags_register
//
// Holds the architectural condition flags {O,N,Z,C} for the execute stage and
// updates them from the ALU, shifter or multiplier as the registered
// controller command directs. Multiplier updates complete out-of-line: a
// LOAD_MULT arms a pending state that is retired by the multValid pulse,
// even while the pipeline is stalled. A 4-deep LIFO shadow stack saves and
// restores the flags across interrupt entry and return.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous active-high reset
//   enable              pipeline advance; low ignores command/write/push/pop
//   resultFlagsControl  command: 0 NO_OP, 1 LOAD_ARITH, 2 LOAD_ARITH_O,
//                       3 LOAD_LOGIC, 4 LOAD_MULT, 5 LOAD_SHIFT, 6-7 NO_OP
//   aluResult/aluCarry/aluOverflow     ALU result and status
//   shiftResult/shiftCarry             shifter result and last bit out
//   multHigh/multLow/multOverflow      product, valid with multValid
//   multValid           single-cycle product-available pulse
//   flagsWrite/flagsWriteData          software write of {O,N,Z,C}
//   pushFlags/popFlags  interrupt save / restore
//   flags               registered {O,N,Z,C}
//   multPending         registered; multiplier update outstanding
//   stackOverflow/stackUnderflow/protocolError  sticky error bits

module result_flags_register (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  resultFlagsControl,
  input  logic [31:0] aluResult,
  input  logic        aluCarry,
  input  logic        aluOverflow,
  input  logic [31:0] shiftResult,
  input  logic        shiftCarry,
  input  logic [31:0] multHigh,
  input  logic [31:0] multLow,
  input  logic        multOverflow,
  input  logic        multValid,
  input  logic        flagsWrite,
  input  logic [3:0]  flagsWriteData,
  input  logic        pushFlags,
  input  logic        popFlags,
  output logic [3:0]  flags,
  output logic        multPending,
  output logic        stackOverflow,
  output logic        stackUnderflow,
  output logic        protocolError
);

  localparam logic [2:0] CMD_NO_OP        = 3'd0;
  localparam logic [2:0] CMD_LOAD_ARITH   = 3'd1;
  localparam logic [2:0] CMD_LOAD_ARITH_O = 3'd2;
  localparam logic [2:0] CMD_LOAD_LOGIC   = 3'd3;
  localparam logic [2:0] CMD_LOAD_MULT    = 3'd4;
  localparam logic [2:0] CMD_LOAD_SHIFT   = 3'd5;

  localparam logic [2:0] STACK_DEPTH = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } pend_state_t;

  // Zero detect on a 32-bit word.
  function automatic logic is_zero32(input logic [31:0] value);
    return (value == 32'd0);
  endfunction

  // True for the codes that actually do something; 6-7 alias NO_OP.
  function automatic logic is_real_cmd(input logic [2:0] cmd);
    logic real_s;
    case (cmd)
      CMD_LOAD_ARITH,
      CMD_LOAD_ARITH_O,
      CMD_LOAD_LOGIC,
      CMD_LOAD_MULT,
      CMD_LOAD_SHIFT: real_s = 1'b1;
      default:        real_s = 1'b0;
    endcase
    return real_s;
  endfunction

  // Flags produced by a completing multiply: carry and overflow both mirror
  // "product does not fit in the low word".
  function automatic logic [3:0] mult_flags(input logic [31:0] high,
                                            input logic [31:0] low,
                                            input logic        ovf);
    return {ovf, high[31], is_zero32(high) & is_zero32(low), ovf};
  endfunction

  pend_state_t state_r, state_next_s;
  logic [3:0]  flags_r, flags_next_s;
  logic [3:0]  stack_r [4];
  logic [2:0]  count_r, count_next_s;
  logic        mult_pending_r;
  logic        ovf_r, unf_r, perr_r;

  logic [3:0]  cmd_flags_s;
  logic [3:0]  top_s;
  logic [1:0]  top_idx_s;
  logic        cmd_take_s;
  logic        cmd_active_s;
  logic        mult_done_s;
  logic        push_do_s;
  logic        pop_do_s;
  logic        ovf_set_s;
  logic        unf_set_s;
  logic        perr_set_s;

  // A command only reaches the flags when nothing of higher priority
  // (pop, software write) is present in the same enabled cycle.
  assign cmd_take_s   = enable & ~popFlags & ~flagsWrite;
  assign cmd_active_s = enable & is_real_cmd(resultFlagsControl);

  // Top-of-stack index; 2-bit wrap maps count 4 onto entry 3.
  assign top_idx_s = count_r[1:0] - 2'd1;
  assign top_s     = stack_r[top_idx_s];

  // Flag values each non-deferred command would produce.
  always_comb begin
    cmd_flags_s = flags_r;
    case (resultFlagsControl)
      CMD_LOAD_ARITH:   cmd_flags_s = {flags_r[3], aluResult[31], is_zero32(aluResult), aluCarry};
      CMD_LOAD_ARITH_O: cmd_flags_s = {aluOverflow, aluResult[31], is_zero32(aluResult), aluCarry};
      CMD_LOAD_LOGIC:   cmd_flags_s = {1'b0, aluResult[31], is_zero32(aluResult), 1'b0};
      CMD_LOAD_SHIFT:   cmd_flags_s = {flags_r[3], shiftResult[31], is_zero32(shiftResult), shiftCarry};
      default:          cmd_flags_s = flags_r;
    endcase
  end

  // Stack control: pop wins over push; full/empty turn the access into an error.
  always_comb begin
    push_do_s    = 1'b0;
    pop_do_s     = 1'b0;
    ovf_set_s    = 1'b0;
    unf_set_s    = 1'b0;
    count_next_s = count_r;
    if (enable && popFlags) begin
      if (count_r == 3'd0) begin
        unf_set_s = 1'b1;
      end else begin
        pop_do_s     = 1'b1;
        count_next_s = count_r - 3'd1;
      end
    end else if (enable && pushFlags) begin
      if (count_r == STACK_DEPTH) begin
        ovf_set_s = 1'b1;
      end else begin
        push_do_s    = 1'b1;
        count_next_s = count_r + 3'd1;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Pending state machine and multiply-completion detection.
  always_comb begin
    state_next_s = state_r;
    mult_done_s  = 1'b0;
    perr_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_take_s && (resultFlagsControl == CMD_LOAD_MULT)) begin
          // Product already on the bus: retire immediately, never go pending.
          if (multValid) begin
            mult_done_s = 1'b1;
          end else begin
            state_next_s = ST_PEND;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        // Completion is independent of enable so a stalled pipe still drains.
        if (multValid) begin
          mult_done_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PEND;
        end
        if (cmd_active_s) begin
          perr_set_s = 1'b1;
        end else begin
          perr_set_s = 1'b0;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Next flag value: multiply completion > pop > software write > command.
  always_comb begin
    flags_next_s = flags_r;
    if (mult_done_s) begin
      flags_next_s = mult_flags(multHigh, multLow, multOverflow);
    end else if (enable && popFlags) begin
      if (pop_do_s) begin
        flags_next_s = top_s;
      end else begin
        flags_next_s = flags_r;
      end
    end else if (enable && flagsWrite) begin
      flags_next_s = flagsWriteData;
    end else if (cmd_take_s && (state_r == ST_IDLE)) begin
      flags_next_s = cmd_flags_s;
    end else begin
      flags_next_s = flags_r;
    end
  end

  // State, flags, stack and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      flags_r        <= 4'd0;
      count_r        <= 3'd0;
      mult_pending_r <= 1'b0;
      ovf_r          <= 1'b0;
      unf_r          <= 1'b0;
      perr_r         <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stack_r[i] <= 4'd0;
      end
    end else begin
      state_r        <= state_next_s;
      flags_r        <= flags_next_s;
      count_r        <= count_next_s;
      mult_pending_r <= (state_next_s == ST_PEND);
      ovf_r          <= ovf_r | ovf_set_s;
      unf_r          <= unf_r | unf_set_s;
      perr_r         <= perr_r | perr_set_s;
      // Push saves the flags as they stood before this cycle's update.
      if (push_do_s) begin
        stack_r[count_r[1:0]] <= flags_r;
      end
    end
  end

  assign flags          = flags_r;
  assign multPending    = mult_pending_r;
  assign stackOverflow  = ovf_r;
  assign stackUnderflow = unf_r;
  assign protocolError  = perr_r;

endmodule

// File: tb/tb_result_flags_register.sv
module tb_result_flags_register;

  localparam logic [2:0] C_NOP = 3'd0;
  localparam logic [2:0] C_AR  = 3'd1;
  localparam logic [2:0] C_ARO = 3'd2;
  localparam logic [2:0] C_LOG = 3'd3;
  localparam logic [2:0] C_MUL = 3'd4;
  localparam logic [2:0] C_SH  = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  resultFlagsControl;
  logic [31:0] aluResult;
  logic        aluCarry;
  logic        aluOverflow;
  logic [31:0] shiftResult;
  logic        shiftCarry;
  logic [31:0] multHigh;
  logic [31:0] multLow;
  logic        multOverflow;
  logic        multValid;
  logic        flagsWrite;
  logic [3:0]  flagsWriteData;
  logic        pushFlags;
  logic        popFlags;
  logic [3:0]  flags;
  logic        multPending;
  logic        stackOverflow;
  logic        stackUnderflow;
  logic        protocolError;

  // Observed status word: {flags[3:0], pend, ovf, unf, perr}
  logic [7:0]  status;
  assign status = {flags, multPending, stackOverflow, stackUnderflow, protocolError};

  always #5 clk = ~clk;

  result_flags_register dut (
    .clk(clk), .reset(reset), .enable(enable),
    .resultFlagsControl(resultFlagsControl),
    .aluResult(aluResult), .aluCarry(aluCarry), .aluOverflow(aluOverflow),
    .shiftResult(shiftResult), .shiftCarry(shiftCarry),
    .multHigh(multHigh), .multLow(multLow), .multOverflow(multOverflow), .multValid(multValid),
    .flagsWrite(flagsWrite), .flagsWriteData(flagsWriteData),
    .pushFlags(pushFlags), .popFlags(popFlags),
    .flags(flags), .multPending(multPending),
    .stackOverflow(stackOverflow), .stackUnderflow(stackUnderflow), .protocolError(protocolError)
  );

  typedef struct {
    string       name;
    logic        en;
    logic [2:0]  cmd;
    logic [31:0] alu;
    logic        ac;
    logic        ao;
    logic [31:0] sh;
    logic        sc;
    logic        wr;
    logic [3:0]  wd;
    logic        push;
    logic        pop;
    logic        mv;
    logic [31:0] mh;
    logic [31:0] ml;
    logic        mo;
    logic [3:0]  exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  localparam int NV = 17;
  vec_t vecs [NV];
  vec_t s;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h ({flags,pend,ovf,unf,perr})", nm, act, exp);
    end
  endtask

  function automatic vec_t idle_vec(input string nm);
    vec_t v;
    v.name = nm; v.en = 1'b1; v.cmd = C_NOP;
    v.alu = 32'h0; v.ac = 1'b0; v.ao = 1'b0; v.sh = 32'h0; v.sc = 1'b0;
    v.wr = 1'b0; v.wd = 4'h0; v.push = 1'b0; v.pop = 1'b0;
    v.mv = 1'b0; v.mh = 32'h0; v.ml = 32'h0; v.mo = 1'b0; v.exp = 4'h0;
    return v;
  endfunction

  task automatic set_inputs(input vec_t v);
    enable = v.en; resultFlagsControl = v.cmd;
    aluResult = v.alu; aluCarry = v.ac; aluOverflow = v.ao;
    shiftResult = v.sh; shiftCarry = v.sc;
    flagsWrite = v.wr; flagsWriteData = v.wd;
    pushFlags = v.push; popFlags = v.pop;
    multValid = v.mv; multHigh = v.mh; multLow = v.ml; multOverflow = v.mo;
  endtask

  // Drive one cycle; the expectation is queued with the stimulus and
  // retired against the DUT one edge later.
  task automatic run(input vec_t v, input logic [7:0] exp);
    exp_t e;
    set_inputs(v);
    e.name = v.name;
    e.exp  = exp;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check(e.name, status, e.exp);
  endtask

  initial begin
    //          name                  en    cmd    alu            ac    ao    sh             sc    wr    wd    push  pop   mv    mh             ml      mo    exp
    vecs[0]  = '{"arith_o_zero",      1'b1, C_ARO, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'hB};
    vecs[1]  = '{"logic_neg",         1'b1, C_LOG, 32'h8000_0000, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'h4};
    vecs[2]  = '{"write_o",           1'b1, C_NOP, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'h8};
    vecs[3]  = '{"arith_hold_o",      1'b1, C_AR,  32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'hD};
    vecs[4]  = '{"shift_zero_hold_o", 1'b1, C_SH,  32'h8000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'hB};
    vecs[5]  = '{"shift_neg",         1'b1, C_SH,  32'h0,         1'b1, 1'b0, 32'h8000_0001, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'hC};
    vecs[6]  = '{"cmd6_noop",         1'b1, 3'd6,  32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'hC};
    vecs[7]  = '{"cmd7_noop",         1'b1, 3'd7,  32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'hC};
    vecs[8]  = '{"disabled_arith",    1'b0, C_ARO, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'hC};
    vecs[9]  = '{"arith_o_ovf",       1'b1, C_ARO, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'h8};
    vecs[10] = '{"stray_mult_valid",  1'b1, C_NOP, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h0, 1'b1, 4'h8};
    vecs[11] = '{"logic_zero",        1'b1, C_LOG, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'h2};
    vecs[12] = '{"write_beats_cmd",   1'b1, C_LOG, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'hF};
    vecs[13] = '{"mult_same_cycle",   1'b1, C_MUL, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0, 1'b1, 4'hD};
    vecs[14] = '{"mult_low_nonzero",  1'b1, C_MUL, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0,         32'h1, 1'b0, 4'h0};
    vecs[15] = '{"disabled_write",    1'b0, C_NOP, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0, 1'b0, 4'h0};
    vecs[16] = '{"disabled_pop",      1'b0, C_NOP, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0, 1'b0, 4'h0};

    reset = 1'b1;
    set_inputs(idle_vec("init"));
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", status, 8'h00);
    reset = 1'b0;

    // Single-cycle flag rules, priority, stall and NO_OP aliases.
    for (int i = 0; i < NV; i++) begin
      run(vecs[i], {vecs[i].exp, 4'h0});
    end

    // Stack: five pushes of written values 1..5, then pop back down.
    s = idle_vec("push_w1"); s.wr = 1'b1; s.wd = 4'h1; run(s, 8'h10);
    for (int k = 2; k <= 5; k++) begin
      logic [3:0] kv;
      kv = 4'(k);
      s = idle_vec("push_wk"); s.wr = 1'b1; s.wd = kv; s.push = 1'b1;
      run(s, {kv, 4'h0});
    end
    s = idle_vec("push_overflow"); s.push = 1'b1; run(s, 8'h54);
    for (int k = 4; k >= 1; k--) begin
      logic [3:0] kv;
      kv = 4'(k);
      s = idle_vec("pop_lifo"); s.pop = 1'b1;
      run(s, {kv, 4'h4});
    end
    s = idle_vec("pop_underflow"); s.pop = 1'b1; run(s, 8'h16);

    // Pop beats write beats command; push alongside pop is ignored.
    s = idle_vec("prio_w3"); s.wr = 1'b1; s.wd = 4'h3; run(s, 8'h36);
    s = idle_vec("prio_push3"); s.push = 1'b1; run(s, 8'h36);
    s = idle_vec("prio_w6"); s.wr = 1'b1; s.wd = 4'h6; run(s, 8'h66);
    s = idle_vec("prio_pop_wins"); s.wr = 1'b1; s.wd = 4'hF; s.pop = 1'b1; s.push = 1'b1;
    s.cmd = C_AR; s.alu = 32'h0; s.ac = 1'b1;
    run(s, 8'h36);
    s = idle_vec("prio_stack_empty"); s.pop = 1'b1; run(s, 8'h36);

    // Deferred multiply: multPending high for exactly three cycles.
    s = idle_vec("mult_arm"); s.cmd = C_MUL; run(s, 8'h3E);
    s = idle_vec("cmd_in_pend"); s.cmd = C_AR; s.alu = 32'h0; s.ac = 1'b1; run(s, 8'h3F);
    s = idle_vec("pend_hold"); run(s, 8'h3F);
    s = idle_vec("mult_complete"); s.mv = 1'b1; run(s, 8'h27);
    s = idle_vec("mult_arm2"); s.cmd = C_MUL; run(s, 8'h2F);
    s = idle_vec("mult_done_stalled"); s.en = 1'b0; s.mv = 1'b1; s.ml = 32'h5; s.mo = 1'b1; run(s, 8'h97);
    s = idle_vec("mv_not_pending"); s.mv = 1'b1; run(s, 8'h97);

    // Reset while pending abandons the multiply.
    s = idle_vec("mult_arm3"); s.cmd = C_MUL; run(s, 8'h9F);
    reset = 1'b1;
    #2;
    check("reset_in_pend", status, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    s = idle_vec("mv_after_reset"); s.mv = 1'b1; s.mh = 32'h8000_0000; s.mo = 1'b1; run(s, 8'h00);
    s = idle_vec("stack_cleared"); s.pop = 1'b1; run(s, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
